// File: rtl/one_to_sixteen_deserializer.sv
// one_to_sixteen_deserializer: MSB-first serial to 16-bit word receiver (clock/resetn, data_input/ss in, data_ack handshake, data_output/data_valid/frame_error/overrun/busy/y_Q/counter_bit out)
module one_to_sixteen_deserializer (
  input  logic        clock,
  input  logic        resetn,
  input  logic        data_input,
  input  logic        ss,
  input  logic        data_ack,
  output logic [15:0] data_output,
  output logic        data_valid,
  output logic        frame_error,
  output logic        overrun,
  output logic        busy,
  output logic [1:0]  y_Q,
  output logic [3:0]  counter_bit
);
  typedef enum logic [1:0] {IDLE = 2'b00, ARM = 2'b01, RECEIVE = 2'b10, RELEASE = 2'b11} state_t;
  state_t      r_state;
  logic [15:0] r_shift;
  logic [15:0] r_dout;
  logic [3:0]  r_cnt;
  logic        r_valid;
  logic        r_ferr;
  logic        r_ovr;
  logic [15:0] w_next;
  assign w_next      = {r_shift[14:0], data_input};
  assign data_output = r_dout;
  assign data_valid  = r_valid;
  assign frame_error = r_ferr;
  assign overrun     = r_ovr;
  assign y_Q         = r_state;
  assign counter_bit = r_cnt;
  assign busy        = (r_state == RECEIVE) | (r_state == RELEASE);
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_dout  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
      if (data_ack) r_valid <= 1'b0;
      case (r_state)
        IDLE: if (!ss) r_state <= ARM;
        ARM: begin
          r_state <= ss ? IDLE : RECEIVE;
          r_shift <= ss ? 16'h0000 : {15'b0, data_input};
          r_cnt   <= ss ? 4'd0 : 4'd1;
        end
        RECEIVE: begin
          if (ss) begin
            r_ferr  <= 1'b1;
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
          end else if (r_cnt == 4'd15) begin
            r_dout  <= w_next;
            r_valid <= 1'b1;
            r_ovr   <= r_valid & ~data_ack;
            r_shift <= w_next;
            r_state <= RELEASE;
            r_cnt   <= '0;
          end else begin
            r_shift <= w_next;
            r_cnt   <= r_cnt + 4'd1;
          end
        end
        RELEASE: if (ss) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_one_to_sixteen_deserializer.sv
// tb_one_to_sixteen_deserializer: scoreboard bench for the 1-to-16 deserializer
module tb_one_to_sixteen_deserializer;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        data_input = 1'b0;
  logic        ss = 1'b1;
  logic        data_ack = 1'b0;
  logic [15:0] data_output;
  logic        data_valid;
  logic        frame_error;
  logic        overrun;
  logic        busy;
  logic [1:0]  y_Q;
  logic [3:0]  counter_bit;
  typedef struct {logic [15:0] w; logic ovr;} exp_t;
  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic m_valid = 1'b0;
  one_to_sixteen_deserializer dut (
    .clock(clock), .resetn(resetn), .data_input(data_input), .ss(ss), .data_ack(data_ack),
    .data_output(data_output), .data_valid(data_valid), .frame_error(frame_error),
    .overrun(overrun), .busy(busy), .y_Q(y_Q), .counter_bit(counter_bit)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_y"}, y_Q, 2'b00);
    chk({tag, "_cnt"}, counter_bit, 4'd0);
    chk({tag, "_dout"}, data_output, 16'h0000);
    chk({tag, "_valid"}, data_valid, 1'b0);
    chk({tag, "_ferr"}, frame_error, 1'b0);
    chk({tag, "_ovr"}, overrun, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask
  task automatic send_frame(input logic [15:0] w, input bit ack_last, input int hold);
    @(negedge clock);
    ss = 1'b0;
    data_input = w[15];
    @(posedge clock);
    for (int i = 15; i >= 0; i--) begin
      @(negedge clock);
      data_input = w[i];
      data_ack = ack_last && (i == 0);
      if (i == 0) begin
        q.push_back('{w, m_valid && !ack_last});
        m_valid = 1'b1;
      end
      @(posedge clock);
    end
    @(negedge clock);
    data_ack = 1'b0;
    repeat (hold) begin
      data_input = 1'($urandom);
      @(posedge clock);
      #1;
      chk("hold_cnt", counter_bit, 4'd0);
      chk("hold_state", y_Q, 2'b11);
      chk("hold_ferr", frame_error, 1'b0);
      @(negedge clock);
    end
    ss = 1'b1;
    @(posedge clock);
    #1;
    chk("post_frame_idle", y_Q, 2'b00);
    chk("ovr_one_cycle", overrun, 1'b0);
  endtask
  task automatic do_ack();
    @(negedge clock);
    data_ack = 1'b1;
    @(posedge clock);
    @(negedge clock);
    data_ack = 1'b0;
    m_valid = 1'b0;
  endtask
  initial begin : monitor
    logic [1:0] prev_y;
    exp_t e;
    prev_y = 2'b00;
    forever begin
      @(posedge clock);
      #1;
      if (prev_y == 2'b10 && y_Q == 2'b11) begin
        if (q.size() == 0) chk("unexpected_word", 1, 0);
        else begin
          e = q.pop_front();
          chk("word", data_output, e.w);
          chk("word_valid", data_valid, 1'b1);
          chk("word_overrun", overrun, e.ovr);
        end
      end
      prev_y = y_Q;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk_reset_vals("reset");
    @(negedge clock);
    resetn = 1'b1;
    send_frame(16'hA5C3, 0, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("valid_held", data_valid, 1'b1);
    do_ack();
    #1;
    chk("ack_clears", data_valid, 1'b0);
    chk("ack_dout_hold", data_output, 16'hA5C3);
    do_ack();
    #1;
    chk("idle_ack_valid", data_valid, 1'b0);
    chk("idle_ack_dout", data_output, 16'hA5C3);
    @(negedge clock);
    ss = 1'b0;
    data_input = 1'b1;
    @(posedge clock);
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      data_input = 1'(i);
      @(posedge clock);
    end
    #1;
    chk("abort_cnt7", counter_bit, 4'd7);
    @(negedge clock);
    ss = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_ferr", frame_error, 1'b1);
    chk("abort_valid", data_valid, 1'b0);
    chk("abort_dout", data_output, 16'hA5C3);
    chk("abort_idle", y_Q, 2'b00);
    @(posedge clock);
    #1;
    chk("ferr_one_cycle", frame_error, 1'b0);
    send_frame(16'h1234, 0, 0);
    do_ack();
    send_frame(16'hFFFF, 0, 0);
    send_frame(16'h0001, 0, 0);
    send_frame(16'hFFFF, 1, 0);
    send_frame(16'h0001, 1, 0);
    #1;
    chk("coinc_valid", data_valid, 1'b1);
    do_ack();
    send_frame(16'h3C96, 0, 10);
    send_frame(16'h6A01, 1, 0);
    do_ack();
    @(negedge clock);
    ss = 1'b0;
    data_input = 1'b1;
    @(posedge clock);
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      data_input = 1'(~i);
      @(posedge clock);
    end
    @(negedge clock);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    chk_reset_vals("midreset");
    @(negedge clock);
    resetn = 1'b1;
    ss = 1'b1;
    m_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("midreset_ferr", frame_error, 1'b0);
    send_frame(16'h8001, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
